// File: rtl/parity_checker_stream_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the streaming parity checker:
//   PAR_EVEN / PAR_ODD : parity-sense encodings carried on odd_mode
//   state_t            : frame-tracking FSM encoding (ST_IDLE, ST_IN_FRAME)
//   parity_err()       : word check, 1 when data/parity disagree with the sense
// -----------------------------------------------------------------------------
package parity_pkg;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_IN_FRAME = 1'b1
   } state_t;

   // Data is passed zero-extended to 64 bits; the extra zeros do not change
   // the XOR reduction, so one function serves every legal DATA_W.
   function automatic logic parity_err(input logic [63:0] data,
                                       input logic        par,
                                       input logic        odd);
      logic sense;
      sense = (odd == PAR_ODD) ? PAR_ODD : PAR_EVEN;
      return (^data) ^ par ^ sense;
   endfunction

endpackage

// File: rtl/parity_checker_stream_if.sv
// -----------------------------------------------------------------------------
// parity_checker_stream_if
// Bundles the observed receive stream and the checker results.
//   Stream : odd_mode, in_valid, in_data[DATA_W], in_parity, in_last
//   Control: clear_cnt
//   Results: out_valid, out_error, frame_valid, frame_error, frame_overrun,
//            err_count[CNT_W], err_sticky
// master = stream source / result consumer, slave = the checker.
// -----------------------------------------------------------------------------
interface parity_checker_stream_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic              odd_mode;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_parity;
   logic              in_last;
   logic              clear_cnt;

   logic              out_valid;
   logic              out_error;
   logic              frame_valid;
   logic              frame_error;
   logic              frame_overrun;
   logic [CNT_W-1:0]  err_count;
   logic              err_sticky;

   modport master (
      output odd_mode, in_valid, in_data, in_parity, in_last, clear_cnt,
      input  out_valid, out_error, frame_valid, frame_error, frame_overrun,
             err_count, err_sticky
   );

   modport slave (
      input  odd_mode, in_valid, in_data, in_parity, in_last, clear_cnt,
      output out_valid, out_error, frame_valid, frame_error, frame_overrun,
             err_count, err_sticky
   );
endinterface

// File: rtl/parity_checker_stream_word_check.sv
// -----------------------------------------------------------------------------
// parity_word_check
// Combinational single-word parity check, one per lane.
//   data : DATA_W-bit word
//   par  : received parity bit
//   odd  : parity sense (0 even, 1 odd)
//   err  : 1 when the word fails the check
// -----------------------------------------------------------------------------
module parity_word_check
   import parity_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              par,
   input  logic              odd,
   output logic              err
);
   logic [63:0] data_ext;

   assign data_ext = 64'(data);
   assign err      = parity_err(data_ext, par, odd);
endmodule

// File: rtl/parity_checker_stream.sv
// -----------------------------------------------------------------------------
// parity_checker_stream
// Observe-only parity checker for a receive stream. Checks every valid word,
// aggregates word errors per frame (with forced close at MAX_FRAME beats when
// in_last never arrives) and keeps a saturating error counter plus sticky flag.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears all state and outputs
//   bus   : parity_checker_stream_if.slave (stream in, results out)
// All results are registered, one cycle after the beat that produced them.
// -----------------------------------------------------------------------------
module parity_checker_stream
   import parity_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_FRAME = 16,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   parity_checker_stream_if.slave  bus
);
   localparam int BEAT_W = $clog2(MAX_FRAME + 1);

   // Counter saturates at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic              word_err;
   logic [BEAT_W-1:0] beat_next;
   logic              at_max;

   state_t            state;
   logic [BEAT_W-1:0] beat_cnt;
   logic              frame_acc;

   logic              vld_p1;
   logic              err_p1;
   logic              frame_vld_p1;
   logic              frame_err_p1;
   logic              frame_ovr_p1;
   logic [CNT_W-1:0]  err_cnt_p1;
   logic              sticky_p1;

   parity_word_check #(
      .DATA_W (DATA_W)
   ) u_word_check (
      .data (bus.in_data),
      .par  (bus.in_parity),
      .odd  (bus.odd_mode),
      .err  (word_err)
   );

   // The current beat would become beat number beat_next of the open frame.
   assign beat_next = beat_cnt + 1'b1;
   assign at_max    = (beat_next == BEAT_W'(MAX_FRAME));

   // ---- stage p0 -> p1: word result, frame tracking, error counter ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         beat_cnt     <= '0;
         frame_acc    <= 1'b0;
         vld_p1       <= 1'b0;
         err_p1       <= 1'b0;
         frame_vld_p1 <= 1'b0;
         frame_err_p1 <= 1'b0;
         frame_ovr_p1 <= 1'b0;
         err_cnt_p1   <= '0;
         sticky_p1    <= 1'b0;
      end else begin
         vld_p1       <= bus.in_valid;
         err_p1       <= bus.in_valid & word_err;
         frame_vld_p1 <= 1'b0;
         frame_err_p1 <= 1'b0;
         frame_ovr_p1 <= 1'b0;

         if (bus.in_valid) begin
            case (state)
               ST_IDLE: begin
                  if (bus.in_last) begin
                     // Single-beat frame closes immediately.
                     frame_vld_p1 <= 1'b1;
                     frame_err_p1 <= word_err;
                  end else begin
                     state     <= ST_IN_FRAME;
                     beat_cnt  <= BEAT_W'(1);
                     frame_acc <= word_err;
                  end
               end
               ST_IN_FRAME: begin
                  if (bus.in_last) begin
                     frame_vld_p1 <= 1'b1;
                     frame_err_p1 <= frame_acc | word_err;
                     state        <= ST_IDLE;
                     beat_cnt     <= '0;
                     frame_acc    <= 1'b0;
                  end else if (at_max) begin
                     // Missing in_last: force-close; the next beat opens a new frame.
                     frame_vld_p1 <= 1'b1;
                     frame_err_p1 <= 1'b1;
                     frame_ovr_p1 <= 1'b1;
                     state        <= ST_IDLE;
                     beat_cnt     <= '0;
                     frame_acc    <= 1'b0;
                  end else begin
                     beat_cnt  <= beat_next;
                     frame_acc <= frame_acc | word_err;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end

         // clear_cnt wins over a coincident erroring beat.
         if (bus.clear_cnt) begin
            err_cnt_p1 <= '0;
            sticky_p1  <= 1'b0;
         end else if (bus.in_valid && word_err) begin
            err_cnt_p1 <= sat_inc(err_cnt_p1);
            sticky_p1  <= 1'b1;
         end
      end
   end

   assign bus.out_valid     = vld_p1;
   assign bus.out_error     = err_p1;
   assign bus.frame_valid   = frame_vld_p1;
   assign bus.frame_error   = frame_err_p1;
   assign bus.frame_overrun = frame_ovr_p1;
   assign bus.err_count     = err_cnt_p1;
   assign bus.err_sticky    = sticky_p1;
endmodule
